// File: rtl/debounce_edge_det.sv
// -----------------------------------------------------------------------------
// debounce_edge_det
//
// Purpose
//   Synchronizes a raw asynchronous level (switch or pin) through two flops,
//   debounces it with a four-state qualification FSM, and reports accepted
//   level changes as a registered level, one-cycle rise/fall pulses and a
//   wrapping change counter.
//
// Parameters
//   STABLE_CNT : consecutive stable synchronized cycles needed to accept a
//                change (legal 2..255)
//   CNT_W      : debounce counter width, must hold STABLE_CNT
//
// Ports
//   clk        in   1  clock, all state updates on rising edge
//   reset      in   1  asynchronous, active-low reset
//   en         in   1  when 0 the FSM and counter hold (synchronizer still runs)
//   din        in   1  raw asynchronous level
//   q          out  1  registered debounced level
//   rise       out  1  one-cycle pulse on an accepted 0->1 change of q
//   fall       out  1  one-cycle pulse on an accepted 1->0 change of q
//   busy       out  1  high while a candidate change is being qualified
//   edge_cnt   out  8  accepted change count, wraps modulo 256
//   fsm_state  out  2  current FSM state (0 ST_LO, 1 CHK_HI, 2 ST_HI, 3 CHK_LO)
//
// Handshake: none. din is a free-running level; outputs are plain levels and
// single-cycle pulses with no valid/ready flow control.
// -----------------------------------------------------------------------------
`default_nettype none

module debounce_edge_det #(
    parameter int STABLE_CNT = 4,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       din,
    output logic       q,
    output logic       rise,
    output logic       fall,
    output logic       busy,
    output logic [7:0] edge_cnt,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        ST_LO  = 2'd0,
        CHK_HI = 2'd1,
        ST_HI  = 2'd2,
        CHK_LO = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // Entering CHK already counts as the first stable cycle, so acceptance
    // happens when the count has reached STABLE_CNT-1 and sync2 still agrees.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    logic             sync1;
    logic             sync2;
    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             q_n;
    logic             rise_n;
    logic             fall_n;
    logic [7:0]       edge_cnt_n;

    // Two-flop synchronizer, independent of en.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    // State register; q, pulses and the change counter are registered here
    // too so the pulses line up with the first cycle q shows its new value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_LO;
            cnt      <= CNT_ZERO;
            q        <= 1'b0;
            rise     <= 1'b0;
            fall     <= 1'b0;
            edge_cnt <= 8'd0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            q        <= q_n;
            rise     <= rise_n;
            fall     <= fall_n;
            edge_cnt <= edge_cnt_n;
        end
    end

    // Next-state logic. Pulses default low so they last exactly one cycle,
    // even when en drops right after an acceptance.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        q_n        = q;
        rise_n     = 1'b0;
        fall_n     = 1'b0;
        edge_cnt_n = edge_cnt;

        if (en) begin
            case (state)
                ST_LO: begin
                    if (sync2) begin
                        state_n = CHK_HI;
                        cnt_n   = CNT_ONE;
                    end
                end
                CHK_HI: begin
                    if (!sync2) begin
                        state_n = ST_LO;
                        cnt_n   = CNT_ZERO;
                    end else if (cnt >= CNT_LAST) begin
                        state_n    = ST_HI;
                        cnt_n      = CNT_ZERO;
                        q_n        = 1'b1;
                        rise_n     = 1'b1;
                        edge_cnt_n = edge_cnt + 8'd1;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
                ST_HI: begin
                    if (!sync2) begin
                        state_n = CHK_LO;
                        cnt_n   = CNT_ONE;
                    end
                end
                CHK_LO: begin
                    if (sync2) begin
                        state_n = ST_HI;
                        cnt_n   = CNT_ZERO;
                    end else if (cnt >= CNT_LAST) begin
                        state_n    = ST_LO;
                        cnt_n      = CNT_ZERO;
                        q_n        = 1'b0;
                        fall_n     = 1'b1;
                        edge_cnt_n = edge_cnt + 8'd1;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_n = ST_LO;
                    cnt_n   = CNT_ZERO;
                end
            endcase
        end
    end

    // Output logic decoded from the registered state only, so busy is glitch
    // free and clears immediately with the asynchronous reset.
    always_comb begin
        busy      = (state == CHK_HI) || (state == CHK_LO);
        fsm_state = state;
    end

endmodule

`default_nettype wire

// File: tb/tb_debounce_edge_det.sv
// -----------------------------------------------------------------------------
// tb_debounce_edge_det
//
// Directed bench for debounce_edge_det with STABLE_CNT=4. Expected pulses
// ({rise, fall, edge_cnt}) are queued when the stimulus that should cause them
// is driven and popped when the DUT pulses; level/busy/state checks are made
// at fixed edge numbers derived from the sync + qualification latency.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_debounce_edge_det;

    localparam int STABLE_CNT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       din;
    logic       q;
    logic       rise;
    logic       fall;
    logic       busy;
    logic [7:0] edge_cnt;
    logic [1:0] fsm_state;

    int         total_cnt = 0;
    int         pass_cnt  = 0;
    logic [9:0] exp_q[$];
    logic [9:0] exp_item;
    logic [7:0] exp_cnt;
    logic       lvl;

    debounce_edge_det #(
        .STABLE_CNT(STABLE_CNT),
        .CNT_W     (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .din      (din),
        .q        (q),
        .rise     (rise),
        .fall     (fall),
        .busy     (busy),
        .edge_cnt (edge_cnt),
        .fsm_state(fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checkers ----------------
    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic check_val(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // ---------------- driver: advance one edge, then score any pulse -------
    task automatic tick();
        @(posedge clk);
        #1;
        if (rise || fall) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_pulse", {rise, fall, edge_cnt}, 10'h000);
            end else begin
                exp_item = exp_q.pop_front();
                check_val("pulse", {rise, fall, edge_cnt}, exp_item);
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0;
        en    = 1'b0;
        din   = 1'b0;

        // Reset state
        #12;
        check_bit("rst_q", q, 1'b0);
        check_bit("rst_rise", rise, 1'b0);
        check_bit("rst_fall", fall, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_val("rst_edge_cnt", {2'b00, edge_cnt}, 10'd0);
        check_val("rst_state", {8'h00, fsm_state}, 10'd0);
        tick();
        reset = 1'b1;
        en    = 1'b1;
        tick();

        // Clean rise: q and rise at edge 6, busy after edges 3..5
        din = 1'b1;
        exp_q.push_back({1'b1, 1'b0, 8'd1});
        for (int i = 1; i <= 7; i++) begin
            tick();
            check_bit("rise_q", q, (i >= 6));
            check_bit("rise_busy", busy, (i >= 3 && i <= 5));
            check_bit("rise_pulse", rise, (i == 6));
        end
        check_val("rise_edge_cnt", {2'b00, edge_cnt}, 10'd1);

        // Clean fall
        din = 1'b0;
        exp_q.push_back({1'b0, 1'b1, 8'd2});
        for (int i = 1; i <= 7; i++) begin
            tick();
            check_bit("fall_q", q, (i < 6));
            check_bit("fall_busy", busy, (i >= 3 && i <= 5));
            check_bit("fall_pulse", fall, (i == 6));
        end
        check_val("fall_edge_cnt", {2'b00, edge_cnt}, 10'd2);

        // Glitch: din high for 3 cycles must not change q
        din = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 3) din = 1'b0;
            check_bit("glitch_q", q, 1'b0);
            check_bit("glitch_busy", busy, (i >= 3 && i <= 5));
            check_bit("glitch_rise", rise, 1'b0);
        end
        check_val("glitch_edge_cnt", {2'b00, edge_cnt}, 10'd2);

        // en gating: 5 frozen cycles inside CHK_HI delay acceptance by 5
        din = 1'b1;
        exp_q.push_back({1'b1, 1'b0, 8'd3});
        repeat (3) tick();
        check_val("gate_enter_chk", {8'h00, fsm_state}, 10'd1);
        en = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_bit("gate_hold_busy", busy, 1'b1);
            check_bit("gate_hold_q", q, 1'b0);
        end
        en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_bit("gate_q", q, (i == 3));
            check_bit("gate_rise", rise, (i == 3));
        end
        tick();
        check_bit("gate_rise_clear", rise, 1'b0);

        // Mismatch seen on resume aborts CHK_LO without a pulse
        din = 1'b0;
        repeat (3) tick();
        check_val("resume_chk_lo", {8'h00, fsm_state}, 10'd3);
        en  = 1'b0;
        din = 1'b1;
        repeat (4) tick();
        check_val("resume_frozen", {8'h00, fsm_state}, 10'd3);
        en = 1'b1;
        tick();
        check_bit("resume_busy", busy, 1'b0);
        check_bit("resume_q", q, 1'b1);
        check_bit("resume_fall", fall, 1'b0);
        repeat (3) tick();
        check_val("resume_state", {8'h00, fsm_state}, 10'd2);
        check_val("resume_edge_cnt", {2'b00, edge_cnt}, 10'd3);

        // Asynchronous reset while busy clears everything before any edge
        din = 1'b0;
        repeat (3) tick();
        check_bit("mid_busy", busy, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check_bit("async_q", q, 1'b0);
        check_bit("async_busy", busy, 1'b0);
        check_bit("async_rise", rise, 1'b0);
        check_bit("async_fall", fall, 1'b0);
        check_val("async_edge_cnt", {2'b00, edge_cnt}, 10'd0);
        check_val("async_state", {8'h00, fsm_state}, 10'd0);
        din = 1'b1;
        tick();
        tick();
        reset = 1'b1;

        // din=1 at reset release: normal rise after the usual latency
        exp_q.push_back({1'b1, 1'b0, 8'd1});
        for (int i = 1; i <= 7; i++) begin
            tick();
            check_bit("rel_q", q, (i >= 6));
            check_bit("rel_rise", rise, (i == 6));
        end
        check_val("rel_edge_cnt", {2'b00, edge_cnt}, 10'd1);

        // Wrap: 255 more accepted changes bring edge_cnt back to 0
        exp_cnt = 8'd1;
        lvl     = 1'b1;
        for (int n = 0; n < 255; n++) begin
            lvl = ~lvl;
            din = lvl;
            exp_cnt = exp_cnt + 8'd1;
            exp_q.push_back({lvl, ~lvl, exp_cnt});
            repeat (6) tick();
            check_bit("wrap_q", q, lvl);
        end
        check_val("wrap_zero", {2'b00, edge_cnt}, 10'd0);
        lvl = ~lvl;
        din = lvl;
        exp_q.push_back({1'b1, 1'b0, 8'd1});
        repeat (6) tick();
        check_bit("post_wrap_q", q, 1'b1);
        check_val("post_wrap_cnt", {2'b00, edge_cnt}, 10'd1);

        repeat (3) tick();
        check_val("queue_empty", 10'(exp_q.size()), 10'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
